mbssoc_ram_responder: RTL and testbench
=======================================

// Module: mbssoc_ram_responder
// PURPOSE
//  RAM-side responder for the arbitrated shared-memory bus driven by the SoC bus controller.
//  Samples ram_re/ram_we/ram_addr, runs WAIT_STATES cycles of access latency, then
//  commits the write or returns read data with a one-cycle ram_ready pulse.
//  Holds a word-addressed on-chip array; ram_busy feeds the bus controller for CPU stalls.
// PARAMETERS
//  ADDR_WIDTH   32  bus address width (matches `ADDR_WIDTH)
//  DATA_WIDTH   32  data word width; multiple of 8
//  DEPTH_LOG2   10  log2 of array depth in words (1024 words)
//  WAIT_STATES  1   extra latency cycles, 0..15
// PORTS
//  clk        in   1            system clock, rising edge
//  rst        in   1            synchronous reset, active-high
//  ram_re     in   1            read request from bus controller
//  ram_we     in   1            write request from bus controller
//  ram_addr   in   ADDR_WIDTH   byte address; word index = ram_addr[DEPTH_LOG2+1:2]
//  ram_wdata  in   DATA_WIDTH   write data
//  ram_be     in   DATA_WIDTH/8 byte-lane write enables (only with MBS_RAM_BYTE_WE_EN)
//  ram_rdata  out  DATA_WIDTH   read data, registered
//  ram_ready  out  1            one-cycle completion pulse
//  ram_err    out  1            completion with error, valid with ram_ready
//  ram_busy   out  1            access in flight; new requests ignored
// BEHAVIOUR
//  - Reset: state IDLE, ram_rdata=0, ram_ready=0, ram_err=0, ram_busy=0, wait counter=0.
//    Array contents are not cleared.
//  - FSM IDLE -> (WAIT) -> RESP -> IDLE:
//    IDLE: on (ram_re|ram_we) at edge N, latch op, addr, wdata (and be); load cnt=WAIT_STATES.
//          Go to WAIT if WAIT_STATES>0, else to RESP.
//    WAIT: decrement cnt each cycle; go to RESP when cnt reaches 1.
//    RESP: ram_ready=1 for exactly this cycle, then IDLE.
//  - Latency: request sampled at edge N -> ram_ready high in cycle N+1+WAIT_STATES.
//  - ram_busy=1 in every WAIT and RESP cycle. Request lines are don't-care while busy;
//    only the latched values are used.
//  - Requester holds its request until it sees ram_ready, then drops it. A request still
//    high in the IDLE cycle after RESP starts a new access (back-to-back allowed; no bubble
//    beyond that IDLE cycle).
//  - Write commit: at the edge entering RESP. Read: ram_rdata loads at the same edge and
//    holds until the next successful read response. Writes leave ram_rdata unchanged.
//  - Error (ram_err=1 with ram_ready, no array access, ram_rdata unchanged):
//    a) ram_addr bits [ADDR_WIDTH-1:DEPTH_LOG2+2] nonzero (out of range);
//    b) ram_re and ram_we both high when sampled;
//    c) ram_addr[1:0] != 0 (misaligned).
//    Full latency still applies.
//  - Reset mid-access: abort immediately to IDLE. A write not yet committed is discarded;
//    no ram_ready is emitted.
//  - ram_err=0 whenever ram_ready=0.
//  - Counter width is 4 bits; WAIT_STATES>15 is illegal; simulation $error at elaboration.
// CONFIGURATION
//  MBS_RAM_BYTE_WE_EN defined:
//    ram_be port present. Write updates only lanes with ram_be[i]=1.
//    ram_be==0 completes normally with no change.
//  MBS_RAM_BYTE_WE_EN undefined:
//    no ram_be port; every write updates the full word.
//  Reads are unaffected by the macro in both cases.
// TESTING
//  1. rst=1 for 2 cycles with ram_re=1 -> all outputs 0, no ram_ready until 1 cycle after
//     rst drops plus latency.
//  2. WAIT_STATES=2: write 0xDEADBEEF @0x10 at edge N -> ram_ready at N+3, ram_busy N+1..N+3.
//     Read @0x10 -> ram_rdata=0xDEADBEEF with ram_ready.
//  3. Back-to-back writes @0x0=0x1, @0x4=0x2, then two reads -> 0x1, 0x2.
//     Each access is separated by exactly one IDLE cycle.
//  4. Read @0x0001_0000 (DEPTH_LOG2=10), re&we together @0x8, read @0x6 -> each gives
//     ram_ready with ram_err=1. ram_rdata unchanged; word @0x8 unchanged.
//  5. Assert rst in the WAIT cycle of a write 0x55 @0x20 -> no ram_ready.
//     Later read @0x20 returns the old value.
//  6. MBS_RAM_BYTE_WE_EN: word 0x11223344, write 0xAABBCCDD with be=4'b0101 -> read 0x11BB33DD.
//     Without the macro, the same write -> 0xAABBCCDD.

Source files
------------

// File: rtl/mbssoc_ram_responder.sv
// mbssoc_ram_responder: RAM-side responder for the arbitrated shared-memory bus.
// A request is captured in IDLE. The block then waits WAIT_STATES cycles and
// completes with a one-cycle ram_ready_o pulse, flagging errors on ram_err_o.
// Optional feature macro: MBS_RAM_BYTE_WE_EN. When it is defined, the block has a
// ram_be_i port and writes only the byte lanes that ram_be_i enables.
module mbssoc_ram_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ram_re_i,
  input  logic                    ram_we_i,
  input  logic [ADDR_WIDTH-1:0]   ram_addr_i,
  input  logic [DATA_WIDTH-1:0]   ram_wdata_i,
`ifdef MBS_RAM_BYTE_WE_EN
  input  logic [DATA_WIDTH/8-1:0] ram_be_i,
`endif
  output logic [DATA_WIDTH-1:0]   ram_rdata_o,
  output logic                    ram_ready_o,
  output logic                    ram_err_o,
  output logic                    ram_busy_o
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [3:0] WS4 = WAIT_STATES[3:0];

  if (WAIT_STATES > 15 || WAIT_STATES < 0) begin : g_ws_chk
    $error("mbssoc_ram_responder: WAIT_STATES must be in 0..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    re_q, we_q, err_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [NB-1:0]           be_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [DATA_WIDTH-1:0]   mem [0:(1<<DEPTH_LOG2)-1];

  // Request decode on the live bus: out of range, re+we together, or misaligned
  logic                    req;
  logic                    live_err;
  logic [DEPTH_LOG2-1:0]   live_idx;
  logic [NB-1:0]           live_be;

  assign req      = ram_re_i | ram_we_i;
  assign live_err = ((ram_addr_i >> (DEPTH_LOG2 + 2)) != '0) |
                    (ram_re_i & ram_we_i) | (ram_addr_i[1:0] != 2'b00);
  assign live_idx = ram_addr_i[DEPTH_LOG2+1:2];
`ifdef MBS_RAM_BYTE_WE_EN
  assign live_be  = ram_be_i;
`else
  assign live_be  = '1;
`endif

  // With WAIT_STATES=0 the access happens at the capture edge itself, so it
  // must use the live bus. Otherwise it uses the captured copy.
  logic                    acc_re, acc_we, acc_err, commit;
  logic [DEPTH_LOG2-1:0]   acc_idx;
  logic [DATA_WIDTH-1:0]   acc_wdata;
  logic [NB-1:0]           acc_be;

  always_comb begin
    if (state_q == S_IDLE) begin
      acc_re = ram_re_i; acc_we = ram_we_i; acc_err = live_err;
      acc_idx = live_idx; acc_wdata = ram_wdata_i; acc_be = live_be;
    end else begin
      acc_re = re_q; acc_we = we_q; acc_err = err_q;
      acc_idx = idx_q; acc_wdata = wdata_q; acc_be = be_q;
    end
  end

  // The edge that enters RESP commits the access. Reset at that edge cancels it.
  assign commit = (state_d == S_RESP) && (state_q != S_RESP) && !rst_i;

  // State register and wait counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: IDLE -> (WAIT x WAIT_STATES) -> RESP -> IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (req) begin
        cnt_d   = WS4;
        state_d = (WS4 != 4'd0) ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture the request in IDLE. Bus lines are ignored while busy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      re_q <= 1'b0; we_q <= 1'b0; err_q <= 1'b0;
      idx_q <= '0; wdata_q <= '0; be_q <= '0;
    end else if (state_q == S_IDLE && req) begin
      re_q <= ram_re_i; we_q <= ram_we_i; err_q <= live_err;
      idx_q <= live_idx; wdata_q <= ram_wdata_i; be_q <= live_be;
    end
  end

  // Array write, byte lane by lane. The array is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (commit && acc_we && !acc_err) begin
      for (int b = 0; b < NB; b++)
        if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
    end
  end

  // Read data register: changes only on a successful read
  always_ff @(posedge clk_i) begin
    if (rst_i)                              rdata_q <= '0;
    else if (commit && acc_re && !acc_err)  rdata_q <= mem[acc_idx];
  end

  // Outputs decoded from the registered state
  always_comb begin
    ram_ready_o = (state_q == S_RESP);
    ram_err_o   = (state_q == S_RESP) & err_q;
    ram_busy_o  = (state_q != S_IDLE);
    ram_rdata_o = rdata_q;
  end

endmodule

// File: tb/tb_mbssoc_ram_responder.sv
// Directed bench for mbssoc_ram_responder with WAIT_STATES=2.
// Latency is counted in clock edges after the request is driven. From idle it is 3.
// When the request is issued during the previous RESP cycle it is 4, which
// includes the single IDLE cycle between the two accesses.
module tb_mbssoc_ram_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        re, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ready, err, busy;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  mbssoc_ram_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(10), .WAIT_STATES(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .ram_re_i(re), .ram_we_i(we),
    .ram_addr_i(addr), .ram_wdata_i(wdata),
`ifdef MBS_RAM_BYTE_WE_EN
    .ram_be_i(be),
`endif
    .ram_rdata_o(rdata), .ram_ready_o(ready), .ram_err_o(err), .ram_busy_o(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drive one request, wait for ram_ready (bounded), then drop the request
  task automatic acc(input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] b,
                     output logic [31:0] rd, output logic e,
                     output int lat, output int nbusy);
    logic rdy;
    re = r; we = w; addr = a; wdata = wd; be = b;
    lat = 0; nbusy = 0; rdy = 1'b0;
    while (!rdy && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy) nbusy++;
      rdy = ready;
    end
    rd = rdata; e = err;
    re = 1'b0; we = 1'b0;
    if (!rdy) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat, nb, seen;

  initial begin
    rst = 1'b1; re = 1'b1; we = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'hF;

    // Reset held for 2 cycles with a read pending
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_busy",  {31'd0, busy},  32'd0);
      chk("rst_err",   {31'd0, err},   32'd0);
      chk("rst_rdata", rdata,          32'd0);
    end
    rst = 1'b0;
    acc(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, rd, e, lat, nb);
    chk("rst_release_lat", lat, 32'd3);
    chk("rst_release_err", {31'd0, e}, 32'd0);

    // Write from idle: 3 cycles busy, ready on the third edge; then read back
    @(posedge clk); #1;
    acc(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat, nb);
    chk("wr10_lat", lat, 32'd3);
    chk("wr10_busy", nb, 32'd3);
    chk("wr10_err", {31'd0, e}, 32'd0);
    acc(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, rd, e, lat, nb);
    chk("rd10_data", rd, 32'hDEADBEEF);
    chk("rd10_lat", lat, 32'd4);

    // Back-to-back accesses, each separated by exactly one IDLE cycle
    acc(1'b0, 1'b1, 32'h0, 32'h1, 4'hF, rd, e, lat, nb);
    chk("b2b_wr0_lat", lat, 32'd4);
    chk("b2b_wr0_busy", nb, 32'd3);
    acc(1'b0, 1'b1, 32'h4, 32'h2, 4'hF, rd, e, lat, nb);
    chk("b2b_wr4_lat", lat, 32'd4);
    acc(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, rd, e, lat, nb);
    chk("b2b_rd0", rd, 32'h1);
    chk("b2b_rd0_lat", lat, 32'd4);
    acc(1'b1, 1'b0, 32'h4, 32'h0, 4'hF, rd, e, lat, nb);
    chk("b2b_rd4", rd, 32'h2);

    // Error cases: full latency, ram_err set, rdata and the array untouched
    acc(1'b0, 1'b1, 32'h8, 32'hCAFEF00D, 4'hF, rd, e, lat, nb);
    chk("wr8_keeps_rdata", rd, 32'h2);
    acc(1'b1, 1'b0, 32'h0001_0000, 32'h0, 4'hF, rd, e, lat, nb);
    chk("oor_err", {31'd0, e}, 32'd1);
    chk("oor_lat", lat, 32'd4);
    chk("oor_rdata", rd, 32'h2);
    acc(1'b1, 1'b1, 32'h8, 32'h12345678, 4'hF, rd, e, lat, nb);
    chk("rewe_err", {31'd0, e}, 32'd1);
    chk("rewe_rdata", rd, 32'h2);
    acc(1'b1, 1'b0, 32'h6, 32'h0, 4'hF, rd, e, lat, nb);
    chk("misal_err", {31'd0, e}, 32'd1);
    chk("misal_rdata", rd, 32'h2);
    acc(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, rd, e, lat, nb);
    chk("rd8_intact", rd, 32'hCAFEF00D);
    chk("rd8_err", {31'd0, e}, 32'd0);

    // Reset during the last WAIT cycle of a write discards the write
    acc(1'b0, 1'b1, 32'h20, 32'h0A0A0A0A, 4'hF, rd, e, lat, nb);
    @(posedge clk); #1;
    we = 1'b1; addr = 32'h20; wdata = 32'h55;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; we = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy",  {31'd0, busy}, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    rst = 1'b0;
    seen = 0;
    chk("abort_ready_now", {31'd0, ready}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ready) seen++;
    end
    chk("abort_no_ready", seen, 32'd0);
    acc(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, rd, e, lat, nb);
    chk("abort_old_value", rd, 32'h0A0A0A0A);
    chk("abort_rd_lat", lat, 32'd3);

    // Byte-lane writes
    acc(1'b0, 1'b1, 32'h30, 32'h11223344, 4'hF, rd, e, lat, nb);
    acc(1'b0, 1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, rd, e, lat, nb);
    acc(1'b1, 1'b0, 32'h30, 32'h0, 4'hF, rd, e, lat, nb);
`ifdef MBS_RAM_BYTE_WE_EN
    chk("be_partial", rd, 32'h11BB33DD);
    acc(1'b0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'b0000, rd, e, lat, nb);
    chk("be_zero_err", {31'd0, e}, 32'd0);
    acc(1'b1, 1'b0, 32'h30, 32'h0, 4'hF, rd, e, lat, nb);
    chk("be_zero_nochange", rd, 32'h11BB33DD);
`else
    chk("full_word_write", rd, 32'hAABBCCDD);
`endif

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
